// File: rtl/vin_pack_pkg.sv
// Shared types and constants for the video-input frame packer.
package vin_pack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HDR    = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DROP   = 2'd3
    } state_t;

    localparam logic [15:0] HDR_MAGIC = 16'hA55A;

    // Header word field offsets (16-bit fields, zero-extended to DW)
    localparam int unsigned HDR_MAGIC_LSB   = 0;
    localparam int unsigned HDR_LINECNT_LSB = 16;
    localparam int unsigned HDR_TSTAMP_LSB  = 32;
    localparam int unsigned HDR_FRCNT_LSB   = 48;

    // FIFO entry is {flags, d}; flags sit above the DW data bits
    typedef struct packed {
        logic sof;
        logic eol;
    } ent_flags_t;

    localparam int unsigned ENT_FLAG_W = 2;

endpackage

// File: rtl/vin_frame_packer_if.sv
// Output word stream of the frame packer: valid/ready with sof/eol tags.
interface vin_frame_packer_if #(
    parameter int unsigned DW = 80
);
    logic [DW-1:0] p_out_d;
    logic          p_out_sof;
    logic          p_out_eol;
    logic          p_out_val;
    logic          p_in_rdy;

    modport master (
        output p_out_d,
        output p_out_sof,
        output p_out_eol,
        output p_out_val,
        input  p_in_rdy
    );

    modport slave (
        input  p_out_d,
        input  p_out_sof,
        input  p_out_eol,
        input  p_out_val,
        output p_in_rdy
    );
endinterface

// File: rtl/vin_pack_fifo.sv
// Synchronous first-word-fall-through FIFO; a write at full is accepted only
// when a read happens in the same cycle.
module vin_pack_fifo #(
    parameter int unsigned W  = 82,
    parameter int unsigned AW = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          wr_ok;
    logic          rd_ok;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign wr_ok = wr & (~full | rd);
    assign rd_ok = rd & ~empty;
    assign rdata = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_ok) wp <= wp + 1'b1;
            if (rd_ok) rp <= rp + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= wdata;
    end

endmodule

// File: rtl/vin_frame_packer.sv
// Camera pixel bus framer: line decimation, per-frame header, sof/eol tagging
// and FWFT buffering toward the recording path. DW must be at least 64.
module vin_frame_packer
    import vin_pack_pkg::*;
#(
    parameter int unsigned CH_NUM  = 10,
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned FIFO_AW = 9
) (
    input  logic                      p_in_clk,
    input  logic                      p_in_rst,
    input  logic [CH_NUM*PIX_W-1:0]   p_in_vd,
    input  logic                      p_in_vin_vs,
    input  logic                      p_in_vin_hs,
    input  logic                      p_in_ext_syn,
    input  logic                      p_in_cfg_en,
    input  logic                      p_in_cfg_hdr_en,
    input  logic [3:0]                p_in_cfg_dec,
    input  logic                      p_in_stat_clr,
    vin_frame_packer_if.master        out_if,
    output logic                      p_out_busy,
    output logic                      p_out_ovf,
    output logic [15:0]               p_out_frcnt,
    output logic [15:0]               p_out_linecnt
);
    localparam int unsigned DW = CH_NUM * PIX_W;
    localparam int unsigned EW = DW + ENT_FLAG_W;

    logic [DW-1:0] vd_r;
    logic          vs_r, hs_r, syn_r;
    logic          vs_prev, hs_prev;
    logic          vs_rise, vs_fall, hs_fall;

    state_t        state;
    logic [3:0]    dec_l;
    logic [3:0]    dec_cnt;
    logic [15:0]   kept_cnt;
    logic [15:0]   tstamp;
    logic [15:0]   frcnt;
    logic [15:0]   linecnt;
    logic [DW-1:0] hold_d;
    logic          hold_vld;
    logic          hold_sof;
    logic          sof_pend;
    logic          wr_q;
    logic [EW-1:0] wr_ent;
    logic          ovf;
    logic          kept;
    logic          beat;
    logic          ovf_ev;
    logic [DW-1:0] hdr_word;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_rd;
    logic [EW-1:0] rd_ent;
    ent_flags_t    rd_flags;

    // Input capture; vs history resets high so an in-progress frame is skipped
    always_ff @(posedge p_in_clk) begin
        if (p_in_rst) begin
            vd_r    <= '0;
            vs_r    <= 1'b1;
            hs_r    <= 1'b0;
            syn_r   <= 1'b0;
            vs_prev <= 1'b1;
            hs_prev <= 1'b0;
        end else begin
            vd_r    <= p_in_vd;
            vs_r    <= p_in_vin_vs;
            hs_r    <= p_in_vin_hs;
            syn_r   <= p_in_ext_syn;
            vs_prev <= vs_r;
            hs_prev <= hs_r;
        end
    end

    assign vs_rise = vs_r & ~vs_prev;
    assign vs_fall = ~vs_r & vs_prev;
    assign hs_fall = ~hs_r & hs_prev;
    assign kept    = (dec_cnt == 4'd0);
    assign beat    = hs_r & vs_r & kept;
    assign fifo_rd = ~fifo_empty & out_if.p_in_rdy;
    assign ovf_ev  = wr_q & fifo_full & ~fifo_rd;

    always_comb begin
        hdr_word = '0;
        hdr_word[HDR_FRCNT_LSB   +: 16] = frcnt;
        hdr_word[HDR_TSTAMP_LSB  +: 16] = tstamp;
        hdr_word[HDR_LINECNT_LSB +: 16] = linecnt;
        hdr_word[HDR_MAGIC_LSB   +: 16] = HDR_MAGIC;
    end

    // Framing FSM; every FIFO write is staged through wr_q/wr_ent
    always_ff @(posedge p_in_clk) begin
        if (p_in_rst) begin
            state    <= ST_IDLE;
            dec_l    <= '0;
            dec_cnt  <= '0;
            kept_cnt <= '0;
            tstamp   <= '0;
            frcnt    <= '0;
            linecnt  <= '0;
            hold_d   <= '0;
            hold_vld <= 1'b0;
            hold_sof <= 1'b0;
            sof_pend <= 1'b0;
            wr_q     <= 1'b0;
            wr_ent   <= '0;
            ovf      <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            if (syn_r) tstamp <= tstamp + 16'd1;
            if (ovf_ev)             ovf <= 1'b1;
            else if (p_in_stat_clr) ovf <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (vs_rise && p_in_cfg_en) begin
                        dec_l    <= p_in_cfg_dec;
                        dec_cnt  <= '0;
                        kept_cnt <= '0;
                        hold_vld <= 1'b0;
                        sof_pend <= ~p_in_cfg_hdr_en;
                        state    <= p_in_cfg_hdr_en ? ST_HDR : ST_ACTIVE;
                    end
                end
                ST_HDR: begin
                    if (ovf_ev) begin
                        state <= ST_DROP;
                    end else begin
                        wr_q   <= 1'b1;
                        wr_ent <= {ent_flags_t'{sof: 1'b1, eol: 1'b0}, hdr_word};
                        state  <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (ovf_ev) begin
                        hold_vld <= 1'b0;
                        state    <= vs_fall ? ST_IDLE : ST_DROP;
                    end else if (vs_fall) begin
                        if (hold_vld) begin
                            wr_q   <= 1'b1;
                            wr_ent <= {ent_flags_t'{sof: hold_sof, eol: 1'b1}, hold_d};
                        end
                        hold_vld <= 1'b0;
                        frcnt    <= frcnt + 16'd1;
                        linecnt  <= kept_cnt + 16'(hs_prev & kept);
                        state    <= ST_IDLE;
                    end else begin
                        if (beat) begin
                            if (hold_vld) begin
                                wr_q   <= 1'b1;
                                wr_ent <= {ent_flags_t'{sof: hold_sof, eol: 1'b0}, hold_d};
                            end
                            hold_d   <= vd_r;
                            hold_sof <= sof_pend;
                            hold_vld <= 1'b1;
                            sof_pend <= 1'b0;
                        end else if (hs_fall && hold_vld) begin
                            wr_q     <= 1'b1;
                            wr_ent   <= {ent_flags_t'{sof: hold_sof, eol: 1'b1}, hold_d};
                            hold_vld <= 1'b0;
                        end
                        if (hs_fall) begin
                            dec_cnt <= (dec_cnt == dec_l) ? 4'd0 : dec_cnt + 4'd1;
                            if (kept) kept_cnt <= kept_cnt + 16'd1;
                        end
                    end
                end
                ST_DROP: begin
                    if (vs_fall) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    vin_pack_fifo #(
        .W  (EW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (p_in_clk),
        .rst   (p_in_rst),
        .wr    (wr_q),
        .wdata (wr_ent),
        .rd    (fifo_rd),
        .rdata (rd_ent),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rd_flags          = rd_ent[EW-1 -: ENT_FLAG_W];
    assign out_if.p_out_d    = rd_ent[DW-1:0];
    assign out_if.p_out_sof  = rd_flags.sof;
    assign out_if.p_out_eol  = rd_flags.eol;
    assign out_if.p_out_val  = ~fifo_empty;

    assign p_out_busy    = (state != ST_IDLE);
    assign p_out_ovf     = ovf;
    assign p_out_frcnt   = frcnt;
    assign p_out_linecnt = linecnt;

endmodule

// File: tb/tb_vin_frame_packer.sv
// Directed bench for vin_frame_packer: header/data framing, decimation,
// ignored start-up frame, mid-frame config change, early vs fall, overflow.
module tb_vin_frame_packer;
    localparam int unsigned CH_NUM  = 10;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned FIFO_AW = 3;
    localparam int unsigned DW      = CH_NUM * PIX_W;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] vd;
    logic          vs, hs, ext_syn, cfg_en, cfg_hdr_en, stat_clr;
    logic [3:0]    cfg_dec;
    logic          busy, ovf;
    logic [15:0]   frcnt, linecnt;

    int checks = 0;
    int errors = 0;
    logic [DW+1:0] q [$];

    vin_frame_packer_if #(.DW(DW)) out_if ();

    vin_frame_packer #(
        .CH_NUM  (CH_NUM),
        .PIX_W   (PIX_W),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .p_in_clk        (clk),
        .p_in_rst        (rst),
        .p_in_vd         (vd),
        .p_in_vin_vs     (vs),
        .p_in_vin_hs     (hs),
        .p_in_ext_syn    (ext_syn),
        .p_in_cfg_en     (cfg_en),
        .p_in_cfg_hdr_en (cfg_hdr_en),
        .p_in_cfg_dec    (cfg_dec),
        .p_in_stat_clr   (stat_clr),
        .out_if          (out_if),
        .p_out_busy      (busy),
        .p_out_ovf       (ovf),
        .p_out_frcnt     (frcnt),
        .p_out_linecnt   (linecnt)
    );

    always #5 clk = ~clk;

    // Record every accepted output word as {sof, eol, d}
    always @(negedge clk) begin
        if (!rst && out_if.p_out_val && out_if.p_in_rdy)
            q.push_back({out_if.p_out_sof, out_if.p_out_eol, out_if.p_out_d});
    end

    function automatic logic [DW-1:0] pix(input int f, input int l, input int b);
        return {8'(b) ^ 8'h5A, 48'd0, 8'(f), 8'(l), 8'(b)};
    endfunction

    function automatic logic [DW+1:0] ent(input logic sof, input logic eol, input logic [DW-1:0] d);
        return {sof, eol, d};
    endfunction

    function automatic logic [DW+1:0] qget(input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    task automatic chk(input string tag, input logic [DW+1:0] obs, input logic [DW+1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_line(input int f, input int l, input int nb);
        for (int b = 0; b < nb; b++) begin
            vd = pix(f, l, b);
            hs = 1'b1;
            tick();
        end
        hs = 1'b0;
        ticks(2);
    endtask

    task automatic syn_pulse();
        ext_syn = 1'b1;
        tick();
        ext_syn = 1'b0;
        tick();
    endtask

    task automatic frame_start();
        vs = 1'b1;
        ticks(3);
    endtask

    task automatic frame_end();
        vs = 1'b0;
        ticks(3);
    endtask

    initial begin
        rst = 1'b1; vd = '0; vs = 1'b1; hs = 1'b0; ext_syn = 1'b0;
        cfg_en = 1'b1; cfg_hdr_en = 1'b1; cfg_dec = 4'd0; stat_clr = 1'b0;
        out_if.p_in_rdy = 1'b1;
        ticks(4);
        rst = 1'b0;
        tick();

        // Reset state, with a frame already in progress
        chk("rst_val",     out_if.p_out_val, 1'b0);
        chk("rst_busy",    busy,             1'b0);
        chk("rst_ovf",     ovf,              1'b0);
        chk("rst_frcnt",   frcnt,            16'd0);
        chk("rst_linecnt", linecnt,          16'd0);

        // Frame active at reset release is ignored
        send_line(9, 0, 2);
        chk("pre_busy", busy, 1'b0);
        frame_end();
        chk("pre_words", q.size(), 0);
        chk("pre_frcnt", frcnt, 16'd0);

        // Header + 4 lines x 3 beats, no decimation
        syn_pulse(); syn_pulse(); syn_pulse();
        q.delete();
        frame_start();
        for (int l = 0; l < 4; l++) send_line(1, l, 3);
        frame_end();
        ticks(20);
        chk("f1_words", q.size(), 13);
        chk("f1_hdr", qget(0), ent(1'b1, 1'b0, DW'(64'h0000_0003_0000_A55A)));
        for (int i = 0; i < 12; i++)
            chk($sformatf("f1_w%0d", i), qget(i + 1), ent(1'b0, (i % 3) == 2, pix(1, i / 3, i % 3)));
        chk("f1_frcnt",   frcnt,   16'd1);
        chk("f1_linecnt", linecnt, 16'd4);

        // dec=2 over 9 lines keeps lines 0, 3, 6
        syn_pulse();
        cfg_dec = 4'd2;
        q.delete();
        frame_start();
        for (int l = 0; l < 9; l++) send_line(2, l, 2);
        frame_end();
        ticks(20);
        chk("f2_words", q.size(), 7);
        chk("f2_hdr", qget(0), ent(1'b1, 1'b0, DW'(64'h0001_0004_0004_A55A)));
        for (int i = 0; i < 6; i++)
            chk($sformatf("f2_w%0d", i), qget(i + 1), ent(1'b0, (i % 2) == 1, pix(2, 3 * (i / 2), i % 2)));
        chk("f2_frcnt",   frcnt,   16'd2);
        chk("f2_linecnt", linecnt, 16'd3);

        // Decimation changed mid-frame: latched dec=1 still applies
        cfg_hdr_en = 1'b0;
        cfg_dec    = 4'd1;
        q.delete();
        frame_start();
        cfg_dec = 4'd0;
        for (int l = 0; l < 4; l++) send_line(4, l, 1);
        frame_end();
        ticks(10);
        chk("f4_words",   q.size(), 2);
        chk("f4_w0",      qget(0), ent(1'b1, 1'b1, pix(4, 0, 0)));
        chk("f4_w1",      qget(1), ent(1'b0, 1'b1, pix(4, 2, 0)));
        chk("f4_frcnt",   frcnt,   16'd3);
        chk("f4_linecnt", linecnt, 16'd2);

        // New dec=0 in effect; vs falls while hs is still high
        q.delete();
        frame_start();
        send_line(5, 0, 1);
        send_line(5, 1, 1);
        vd = pix(5, 2, 0); hs = 1'b1; tick();
        vd = pix(5, 2, 1); tick();
        vs = 1'b0; vd = pix(5, 2, 2); tick();
        hs = 1'b0;
        ticks(10);
        chk("f5_words",   q.size(), 4);
        chk("f5_w0",      qget(0), ent(1'b1, 1'b1, pix(5, 0, 0)));
        chk("f5_w1",      qget(1), ent(1'b0, 1'b1, pix(5, 1, 0)));
        chk("f5_w2",      qget(2), ent(1'b0, 1'b0, pix(5, 2, 0)));
        chk("f5_w3",      qget(3), ent(1'b0, 1'b1, pix(5, 2, 1)));
        chk("f5_frcnt",   frcnt,   16'd4);
        chk("f5_linecnt", linecnt, 16'd3);

        // Overflow: 20 beats into an 8-deep FIFO with no drain
        out_if.p_in_rdy = 1'b0;
        q.delete();
        frame_start();
        send_line(3, 0, 20);
        chk("ov_ovf",  ovf,  1'b1);
        chk("ov_busy", busy, 1'b1);
        chk("ov_val",  out_if.p_out_val, 1'b1);
        chk("ov_head", {out_if.p_out_sof, out_if.p_out_eol, out_if.p_out_d}, ent(1'b1, 1'b0, pix(3, 0, 0)));
        frame_end();
        ticks(2);
        chk("ov_idle",    busy,    1'b0);
        chk("ov_frcnt",   frcnt,   16'd4);
        chk("ov_linecnt", linecnt, 16'd3);
        chk("ov_sticky",  ovf,     1'b1);
        chk("ov_nopop",   q.size(), 0);
        stat_clr = 1'b1; tick();
        stat_clr = 1'b0; tick();
        chk("ov_clr", ovf, 1'b0);
        out_if.p_in_rdy = 1'b1;
        ticks(15);
        chk("ov_words", q.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("ov_w%0d", i), qget(i), ent(i == 0, 1'b0, pix(3, 0, i)));
        chk("ov_drained", out_if.p_out_val, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
